// File: rtl/core_pkg.sv
// core_pkg: opcode/funct3 constants and the issue request record shared by the integer execute path.
package core_pkg;
    localparam int CORE_XLEN   = 32;
    localparam int CORE_ROB_W  = 3;
    localparam int CORE_PREG_W = 7;
    localparam logic [4:0] R_TYPE = 5'b01100;
    localparam logic [4:0] I_TYPE = 5'b00100;
    localparam logic [4:0] B_TYPE = 5'b11000;
    localparam logic [4:0] LUI    = 5'b01101;
    localparam logic [4:0] AUIPC  = 5'b00101;
    localparam logic [4:0] JAL    = 5'b11011;
    localparam logic [4:0] JALR   = 5'b11001;
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    typedef struct packed {
        logic [CORE_XLEN-1:0]   rs1;
        logic [CORE_XLEN-1:0]   rs2;
        logic [CORE_XLEN-1:0]   imm;
        logic [CORE_XLEN-1:0]   pc;
        logic [CORE_ROB_W-1:0]  rob_idx;
        logic [CORE_PREG_W-1:0] rd;
        logic                   pred_taken;
        logic [CORE_XLEN-1:0]   pred_target;
    } alu_req_t;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: issue, writeback, branch-resolution and flush signals of the integer execute unit.
interface alu_exec_unit_if #(
    parameter int XLEN      = 32,
    parameter int ROB_DEPTH = 8,
    parameter int PREG_W    = 7
);
    localparam int ROB_W = $clog2(ROB_DEPTH);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic              in_funct7;
    logic [XLEN-1:0]   in_rs1;
    logic [XLEN-1:0]   in_rs2;
    logic [XLEN-1:0]   in_imm;
    logic [XLEN-1:0]   in_pc;
    logic [ROB_W-1:0]  in_rob_idx;
    logic [PREG_W-1:0] in_rd;
    logic              in_pred_taken;
    logic [XLEN-1:0]   in_pred_target;
    logic              out_valid;
    logic              out_ready;
    logic [ROB_W-1:0]  out_rob_idx;
    logic [PREG_W-1:0] out_rd;
    logic [XLEN-1:0]   out_data;
    logic              br_valid;
    logic [ROB_W-1:0]  br_rob_idx;
    logic              br_mispredict;
    logic [XLEN-1:0]   br_target;
    logic [ROB_W-1:0]  rob_head;
    logic              flush_valid;
    logic [ROB_W-1:0]  flush_rob_idx;
    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, in_pc,
               in_rob_idx, in_rd, in_pred_taken, in_pred_target, out_ready, rob_head,
               flush_valid, flush_rob_idx,
        output in_ready, out_valid, out_rob_idx, out_rd, out_data, br_valid, br_rob_idx,
               br_mispredict, br_target
    );
    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, in_pc,
               in_rob_idx, in_rd, in_pred_taken, in_pred_target, out_ready, rob_head,
               flush_valid, flush_rob_idx,
        input  in_ready, out_valid, out_rob_idx, out_rd, out_data, br_valid, br_rob_idx,
               br_mispredict, br_target
    );
endinterface

// File: rtl/alu_exec_unit_core.sv
// alu_core: combinational ALU result and branch/jump resolution against the front-end prediction.
module alu_core import core_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_pred_target,
    output logic [XLEN-1:0] o_result,
    output logic            o_wb,
    output logic            o_ctrl,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_target
);
    localparam int SH = $clog2(XLEN);
    logic [XLEN-1:0] w_op2, w_alu, w_pc4, w_pcimm;
    logic [SH-1:0]   w_sh;
    logic            w_lt, w_ltu, w_eq, w_cmp, w_taken;
    always_comb begin
        w_op2   = (i_opcode == R_TYPE) ? i_rs2 : i_imm;
        w_sh    = w_op2[SH-1:0];
        w_lt    = $signed(i_rs1) < $signed(w_op2);
        w_ltu   = i_rs1 < w_op2;
        w_pc4   = i_pc + XLEN'(4);
        w_pcimm = i_pc + i_imm;
        case (i_funct3)
            F3_ADD:  w_alu = (i_opcode == R_TYPE && i_funct7) ? i_rs1 - w_op2 : i_rs1 + w_op2;
            F3_SLL:  w_alu = i_rs1 << w_sh;
            F3_SLT:  w_alu = {{(XLEN-1){1'b0}}, w_lt};
            F3_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_ltu};
            F3_XOR:  w_alu = i_rs1 ^ w_op2;
            F3_SR:   w_alu = i_funct7 ? $unsigned($signed(i_rs1) >>> w_sh) : i_rs1 >> w_sh;
            F3_OR:   w_alu = i_rs1 | w_op2;
            default: w_alu = i_rs1 & w_op2;
        endcase
        // branches compare rs1 against rs2, never against the immediate
        w_eq  = i_rs1 == i_rs2;
        case (i_funct3)
            F3_BEQ:  w_cmp = w_eq;
            F3_BNE:  w_cmp = !w_eq;
            F3_BLT:  w_cmp = $signed(i_rs1) < $signed(i_rs2);
            F3_BGE:  w_cmp = !($signed(i_rs1) < $signed(i_rs2));
            F3_BLTU: w_cmp = i_rs1 < i_rs2;
            F3_BGEU: w_cmp = !(i_rs1 < i_rs2);
            default: w_cmp = 1'b0;
        endcase
        o_ctrl   = i_opcode == B_TYPE || i_opcode == JAL || i_opcode == JALR;
        o_wb     = i_opcode != B_TYPE;
        w_taken  = (i_opcode == B_TYPE) ? w_cmp : o_ctrl;
        o_target = (i_opcode == JALR) ? ((i_rs1 + i_imm) & ~XLEN'(1)) : w_taken ? w_pcimm : w_pc4;
        o_mispredict = (w_taken != i_pred_taken) || (w_taken && o_target != i_pred_target);
        o_result = (i_opcode == R_TYPE || i_opcode == I_TYPE) ? w_alu :
                   (i_opcode == LUI) ? i_imm :
                   (i_opcode == AUIPC) ? w_pcimm :
                   (i_opcode == JAL || i_opcode == JALR) ? w_pc4 : '0;
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: one-slot registered execute stage with branch-resolution pulse and ROB-age flush.
module alu_exec_unit #(
    parameter int XLEN      = 32,
    parameter int ROB_DEPTH = 8,
    parameter int PREG_W    = 7
) (
    input logic            clk,
    input logic            rst_n,
    alu_exec_unit_if.slave bus
);
    localparam int ROB_W = $clog2(ROB_DEPTH);
    logic [XLEN-1:0]   w_result, w_target, r_out_data, r_br_target;
    logic              w_wb, w_ctrl, w_misp, w_accept, w_in_kill, w_slot_kill, w_take;
    logic              r_out_valid, r_br_valid, r_br_misp;
    logic [ROB_W-1:0]  r_out_rob, r_br_rob, w_flush_age;
    logic [PREG_W-1:0] r_out_rd;
    function automatic logic [ROB_W-1:0] age(input logic [ROB_W-1:0] idx, input logic [ROB_W-1:0] head);
        return idx - head;
    endfunction
    alu_core #(.XLEN(XLEN)) u_core (
        .i_opcode(bus.in_opcode), .i_funct3(bus.in_funct3), .i_funct7(bus.in_funct7),
        .i_rs1(bus.in_rs1), .i_rs2(bus.in_rs2), .i_imm(bus.in_imm), .i_pc(bus.in_pc),
        .i_pred_taken(bus.in_pred_taken), .i_pred_target(bus.in_pred_target),
        .o_result(w_result), .o_wb(w_wb), .o_ctrl(w_ctrl), .o_mispredict(w_misp), .o_target(w_target)
    );
    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_flush_age  = age(bus.flush_rob_idx, bus.rob_head);
    assign w_in_kill    = bus.flush_valid && age(bus.in_rob_idx, bus.rob_head) > w_flush_age;
    assign w_slot_kill  = bus.flush_valid && age(r_out_rob, bus.rob_head) > w_flush_age;
    assign w_take       = w_accept && !w_in_kill;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_rob   <= '0;
            r_out_rd    <= '0;
            r_out_data  <= '0;
            r_br_valid  <= 1'b0;
            r_br_rob    <= '0;
            r_br_misp   <= 1'b0;
            r_br_target <= '0;
        end else begin
            // a draining or flushed slot empties unless refilled by this cycle's accept
            if (w_take && w_wb) begin
                r_out_valid <= 1'b1;
                r_out_rob   <= bus.in_rob_idx;
                r_out_rd    <= bus.in_rd;
                r_out_data  <= w_result;
            end else if (bus.out_ready || w_slot_kill) begin
                r_out_valid <= 1'b0;
            end
            r_br_valid <= w_take && w_ctrl;
            r_br_misp  <= w_take && w_ctrl && w_misp;
            if (w_take && w_ctrl) begin
                r_br_rob    <= bus.in_rob_idx;
                r_br_target <= w_target;
            end
        end
    end
    assign bus.out_valid     = r_out_valid;
    assign bus.out_rob_idx   = r_out_rob;
    assign bus.out_rd        = r_out_rd;
    assign bus.out_data      = r_out_data;
    assign bus.br_valid      = r_br_valid;
    assign bus.br_rob_idx    = r_br_rob;
    assign bus.br_mispredict = r_br_misp;
    assign bus.br_target     = r_br_target;
endmodule
